// File: rtl/mem_wait_bridge_pkg.sv
// Shared constants for the memory wait-state bridge: word size, FSM state and op encodings.
package mem_wait_bridge_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_wait_bridge_if.sv
// CPU <-> memory bus. The shared data line is resolved here from the two sides' drive enables.
interface mem_wait_bridge_if import mem_wait_bridge_pkg::*; #(
  parameter int WORD_W = WORD_SIZE
);
  logic              readM;
  logic              writeM;
  logic [WORD_W-1:0] address;
  logic              inputReady;
  logic              busy;
  logic              proto_err;

  logic [WORD_W-1:0] mem_dat;
  logic              mem_oe;
  logic [WORD_W-1:0] cpu_dat;
  logic              cpu_oe;
  wire  [WORD_W-1:0] data;

  // Memory has priority only because the CPU must never drive during a read response.
  assign data = mem_oe ? mem_dat : (cpu_oe ? cpu_dat : {WORD_W{1'bz}});

  modport master (
    output readM, writeM, address, cpu_dat, cpu_oe,
    input  data, inputReady, busy, proto_err, mem_oe
  );

  modport slave (
    input  readM, writeM, address, data,
    output inputReady, busy, proto_err, mem_dat, mem_oe
  );
endinterface

// File: rtl/mem_bridge_ram.sv
// Single-port word RAM: synchronous write, registered read (one edge after re).
// Kept separate from the FSM so a vendor macro can replace it.
module mem_bridge_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_wait_bridge.sv
// Memory endpoint with fixed LATENCY wait states; one inputReady pulse per access, held requests parked in HOLD.
// Optional MEM_STATS_EN adds rd_count/wr_count completed-access counters.
module mem_wait_bridge import mem_wait_bridge_pkg::*; #(
  parameter int WORD_W  = WORD_SIZE,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_wait_bridge_if.slave  bus
`ifdef MEM_STATS_EN
  ,
  output logic [WORD_W-1:0] rd_count,
  output logic [WORD_W-1:0] wr_count
`endif
);

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rd_reg;
  logic [3:0]        cnt;
  logic              ready_q;
  logic              busy_q;
  logic              perr_q;

  logic              req_none;
  logic              fire;
  logic              ram_we;
  logic              ram_re;
  logic              unused_addr;

  assign req_none    = !bus.readM && !bus.writeM;
  assign fire        = (state == ST_WAIT) && (cnt == 4'd0);
  assign ram_we      = fire && (op_q == OP_WRITE);
  assign ram_re      = fire && (op_q == OP_READ);
  assign unused_addr = ^bus.address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.readM && bus.writeM) begin
            perr_q <= 1'b1;
          end else if (bus.readM ^ bus.writeM) begin
            op_q   <= bus.writeM ? OP_WRITE : OP_READ;
            addr_q <= bus.address[ADDR_W-1:0];
            if (bus.writeM) wdata_q <= bus.data;
            cnt    <= 4'(LATENCY - 1);
            state  <= ST_WAIT;
            busy_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= ST_DONE;
            ready_q <= 1'b1;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b0;
          if (req_none) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A request still held after completion must not start a second access.
          if (req_none) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_bridge_ram #(
    .DATA_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rd_reg)
  );

  assign bus.inputReady = ready_q;
  assign bus.busy       = busy_q;
  assign bus.proto_err  = perr_q;
  assign bus.mem_dat    = rd_reg;
  // Released combinationally the moment readM falls.
  assign bus.mem_oe     = (op_q == OP_READ) && ((state == ST_DONE) || (state == ST_HOLD)) && bus.readM;

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (fire) begin
      if (op_q == OP_WRITE) wr_count <= wr_count + 1'b1;
      else                  rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench: two bridges (LATENCY 2 and 1) share one stimulus set, selected by sel.
module tb_mem_wait_bridge;
  import mem_wait_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        cpu_oe = 1'b0;
  logic [15:0] adr = 16'h0;
  logic [15:0] cpu_dat = 16'h0;

  int n_chk = 0;
  int n_fail = 0;
  int lat;
  int pulses;
  int busy_cyc;

  always #5 clk = ~clk;

  mem_wait_bridge_if ba ();
  mem_wait_bridge_if bb ();

  assign ba.readM   = rd & ~sel;
  assign ba.writeM  = wr & ~sel;
  assign ba.address = adr;
  assign ba.cpu_dat = cpu_dat;
  assign ba.cpu_oe  = cpu_oe & ~sel;
  assign bb.readM   = rd & sel;
  assign bb.writeM  = wr & sel;
  assign bb.address = adr;
  assign bb.cpu_dat = cpu_dat;
  assign bb.cpu_oe  = cpu_oe & sel;

`ifdef MEM_STATS_EN
  logic [15:0] rc_a, wc_a, rc_b, wc_b;
`endif

  mem_wait_bridge #(.LATENCY(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ba)
`ifdef MEM_STATS_EN
    ,
    .rd_count (rc_a),
    .wr_count (wc_a)
`endif
  );

  mem_wait_bridge #(.LATENCY(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bb)
`ifdef MEM_STATS_EN
    ,
    .rd_count (rc_b),
    .wr_count (wc_b)
`endif
  );

  logic        ir, bsy, perr, oe;
  logic [15:0] dbus;
  always_comb begin
    ir   = sel ? bb.inputReady : ba.inputReady;
    bsy  = sel ? bb.busy       : ba.busy;
    perr = sel ? bb.proto_err  : ba.proto_err;
    oe   = sel ? bb.mem_oe     : ba.mem_oe;
    dbus = sel ? bb.data       : ba.data;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises a request, scrambles address/data after acceptance, returns edges until inputReady (-1 on timeout).
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, output int l);
    rd = ~w; wr = w; adr = a; cpu_dat = d; cpu_oe = w;
    l = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      l++;
      if (i == 0) begin
        adr = ~a;
        cpu_dat = ~d;
      end
      if (ir) break;
    end
    if (!ir) l = -1;
  endtask

  task automatic drop();
    rd = 1'b0; wr = 1'b0; cpu_oe = 1'b0;
    tick();
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", ir, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_perr", perr, 0);
    chk("rst_oe", oe, 0);
    #19 reset = 1'b0;
    tick();
    chk("idle_busy", bsy, 0);

    // Preload then read with hold
    access(1'b1, 16'h0005, 16'hBEEF, lat);
    chk("wr5_lat", lat, 3);
    drop();
    access(1'b0, 16'h0005, 16'h0000, lat);
    chk("rd5_lat", lat, 3);
    chk("rd5_data", dbus, 16'hBEEF);
    chk("rd5_oe", oe, 1);
    tick();
    chk("rd5_no_repeat", ir, 0);
    chk("rd5_hold_data", dbus, 16'hBEEF);
    chk("rd5_hold_busy", bsy, 1);
    rd = 1'b0;
    #1;
    chk("rd5_release", oe, 0);
    tick();
    chk("rd5_idle", bsy, 0);

    // Write then read
    access(1'b1, 16'h0010, 16'h1234, lat);
    chk("wr10_lat", lat, 3);
    chk("wr10_oe", oe, 0);
    drop();
    access(1'b0, 16'h0010, 16'h0000, lat);
    chk("rd10_lat", lat, 3);
    chk("rd10_data", dbus, 16'h1234);
    drop();

    // Held request
    access(1'b0, 16'h0010, 16'h0000, lat);
    chk("held_lat", lat, 3);
    pulses = 0;
    busy_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ir) pulses++;
      if (bsy) busy_cyc++;
    end
    chk("held_pulses", pulses, 0);
    chk("held_busy", busy_cyc, 6);
    drop();
    chk("held_release", bsy, 0);

    // Illegal request
    rd = 1'b1; wr = 1'b1; adr = 16'h0010; cpu_dat = 16'h9999; cpu_oe = 1'b1;
    tick();
    chk("ill_perr", perr, 1);
    chk("ill_busy", bsy, 0);
    chk("ill_ready", ir, 0);
    tick();
    chk("ill_ready2", ir, 0);
    drop();
    access(1'b0, 16'h0010, 16'h0000, lat);
    chk("ill_ram", dbus, 16'h1234);
    drop();
    chk("ill_sticky", perr, 1);

    // Reset abort
    access(1'b1, 16'h0020, 16'h1111, lat);
    chk("wr20_lat", lat, 3);
    drop();
    rd = 1'b0; wr = 1'b1; adr = 16'h0020; cpu_dat = 16'hAAAA; cpu_oe = 1'b1;
    tick();
    chk("abort_busy", bsy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy_rst", bsy, 0);
    chk("abort_ready_rst", ir, 0);
    chk("abort_perr_rst", perr, 0);
    chk("abort_oe_rst", oe, 0);
    drop();
    reset = 1'b0;
    tick();
    access(1'b0, 16'h0020, 16'h0000, lat);
    chk("abort_ram", dbus, 16'h1111);
    drop();
`ifdef MEM_STATS_EN
    chk("a_rd_count", rc_a, 1);
    chk("a_wr_count", wc_a, 0);
`endif

    // Latency 1 and address wrap
    sel = 1'b1;
    tick();
    access(1'b1, 16'h0403, 16'h5A5A, lat);
    chk("l1_wr_lat", lat, 2);
    drop();
    access(1'b0, 16'h0003, 16'h0000, lat);
    chk("l1_rd_lat", lat, 2);
    chk("l1_wrap_data", dbus, 16'h5A5A);
    drop();
    chk("l1_idle", bsy, 0);
`ifdef MEM_STATS_EN
    chk("b_wr_count", wc_b, 1);
    chk("b_rd_count", rc_b, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
